// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM encoding,
// iteration constants and the operand magnitude helper.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'b000;
    localparam logic [2:0] MDU_MULTU = 3'b001;
    localparam logic [2:0] MDU_DIV   = 3'b010;
    localparam logic [2:0] MDU_DIVU  = 3'b011;
    localparam logic [2:0] MDU_MTHI  = 3'b100;
    localparam logic [2:0] MDU_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

    localparam int          ITER_COUNT  = 32;
    localparam int          CNT_W       = $clog2(ITER_COUNT);
    localparam logic [31:0] DIV_ZERO_LO = 32'hFFFFFFFF;

    // Unsigned magnitude; 0x80000000 maps to itself, which is correct as unsigned.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// One radix-2 iteration: shift-add multiply over {hi,lo} or restoring
// shift-subtract divide with remainder in hi and quotient shifting into lo.
module mdu_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             mul_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   shl_s;
    logic [WIDTH+1:0] diff_s;

    // Both step flavours are computed; the flag picks which one is committed.
    always_comb begin
        sum_s  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
        shl_s  = {hi_i, lo_i[WIDTH-1]};
        diff_s = {1'b0, shl_s} - {2'b00, opnd_i};
        if (mul_i) begin
            hi_o = sum_s[WIDTH:1];
            lo_o = {sum_s[0], lo_i[WIDTH-1:1]};
        end else if (diff_s[WIDTH+1]) begin
            hi_o = shl_s[WIDTH-1:0];
            lo_o = {lo_i[WIDTH-2:0], 1'b0};
        end else begin
            hi_o = diff_s[WIDTH-1:0];
            lo_o = {lo_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle MULT/DIV unit with architectural HI/LO registers and a stall
// request for the EX stage.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iStart,
    input  logic [2:0]       iOp,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    output logic [WIDTH-1:0] oHi,
    output logic [WIDTH-1:0] oLo,
    output logic             oBusy,
    output logic             oDone,
    output logic             oStall
);

    mdu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] acc_q, low_q, opnd_q;
    logic             is_mul_q, neg_lo_q, neg_hi_q, div0_q;
    logic             busy_q, done_q;

    logic             signed_s;
    logic [WIDTH-1:0] core_hi_s, core_lo_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0] fix_hi_s, fix_lo_s;

    assign signed_s = ~iOp[0];

    mdu_iter_core #(.WIDTH(WIDTH)) u_core (
        .mul_i  (is_mul_q),
        .hi_i   (acc_q),
        .lo_i   (low_q),
        .opnd_i (opnd_q),
        .hi_o   (core_hi_s),
        .lo_o   (core_lo_s)
    );

    // Sign correction of the raw magnitude result, committed in FIX.
    always_comb begin
        prod_s = {acc_q, low_q};
        if (is_mul_q) begin
            if (neg_lo_q) begin
                prod_s = {(2*WIDTH){1'b0}} - prod_s;
            end else begin
                prod_s = {acc_q, low_q};
            end
            fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_s[WIDTH-1:0];
        end else begin
            // The restoring loop already leaves |iA| as remainder on a zero divisor.
            fix_hi_s = neg_hi_q ? ({WIDTH{1'b0}} - acc_q) : acc_q;
            if (div0_q) begin
                fix_lo_s = DIV_ZERO_LO;
            end else begin
                fix_lo_s = neg_lo_q ? ({WIDTH{1'b0}} - low_q) : low_q;
            end
        end
    end

    // FSM, iteration registers and HI/LO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            acc_q    <= {WIDTH{1'b0}};
            low_q    <= {WIDTH{1'b0}};
            opnd_q   <= {WIDTH{1'b0}};
            is_mul_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (iStart) begin
                        case (iOp)
                            MDU_MTHI: hi_q <= iA;
                            MDU_MTLO: lo_q <= iA;
                            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                                state_q  <= CALC;
                                busy_q   <= 1'b1;
                                cnt_q    <= {CNT_W{1'b0}};
                                is_mul_q <= ~iOp[1];
                                acc_q    <= {WIDTH{1'b0}};
                                low_q    <= mag32(iA, signed_s);
                                opnd_q   <= mag32(iB, signed_s);
                                neg_lo_q <= signed_s & (iA[WIDTH-1] ^ iB[WIDTH-1]);
                                neg_hi_q <= signed_s & iA[WIDTH-1];
                                div0_q   <= iOp[1] & (iB == {WIDTH{1'b0}});
                            end
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    acc_q <= core_hi_s;
                    low_q <= core_lo_s;
                    cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == CNT_W'(ITER_COUNT - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    hi_q    <= fix_hi_s;
                    lo_q    <= fix_lo_s;
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign oHi    = hi_q;
    assign oLo    = lo_q;
    assign oBusy  = busy_q;
    assign oDone  = done_q;
    assign oStall = iStart & busy_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: behavioural model feeds a scoreboard that
// is drained on each oDone pulse.
module tb_mdu_hilo;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             iStart;
    logic [2:0]       iOp;
    logic [WIDTH-1:0] iA, iB;
    logic [WIDTH-1:0] oHi, oLo;
    logic             oBusy, oDone, oStall;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] sb_q[$];

    always #5 clk = ~clk;

    mdu_hilo #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .iStart (iStart),
        .iOp    (iOp),
        .iA     (iA),
        .iB     (iB),
        .oHi    (oHi),
        .oLo    (oLo),
        .oBusy  (oBusy),
        .oDone  (oDone),
        .oStall (oStall)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference {HI,LO} from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa, sbv, sq, sr;
        longint unsigned ua, ub, uq, ur;
        sa  = {{32{a[31]}}, a};
        sbv = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        case (op)
            3'b000: begin sq = sa * sbv; return sq; end
            3'b001: begin uq = ua * ub; return uq; end
            3'b010: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                sq = sa / sbv;
                sr = sa % sbv;
                return {sr[31:0], sq[31:0]};
            end
            3'b011: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            default: return {oHi, oLo};
        endcase
    endfunction

    // Issue one MULT/DIV, then track latency, HI/LO stability and the result.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        logic [63:0] old;
        int          cyc;
        logic        changed;
        sb_q.push_back(model(op, a, b));
        old = {oHi, oLo};
        @(negedge clk);
        iStart = 1'b1; iOp = op; iA = a; iB = b;
        @(negedge clk);
        iStart = 1'b0;
        check({tag, "_busy"}, {63'd0, oBusy}, 64'd1);
        cyc = 1;
        changed = 1'b0;
        while (!oDone && cyc < 60) begin
            if ({oHi, oLo} !== old) changed = 1'b1;
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'd34);
        check({tag, "_stable"}, {63'd0, changed}, 64'd0);
        check({tag, "_hilo"}, {oHi, oLo}, sb_q.pop_front());
        check({tag, "_idle"}, {63'd0, oBusy}, 64'd0);
        @(negedge clk);
        check({tag, "_pulse"}, {63'd0, oDone}, 64'd0);
    endtask

    initial begin
        logic [63:0] exp;
        logic [31:0] old_lo;
        logic        stall_bad, lo_bad, done_seen;
        int          cyc;

        rst = 1'b1; iStart = 1'b0; iOp = 3'b000; iA = 32'd0; iB = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_hilo", {oHi, oLo}, 64'd0);
        check("rst_busy_done", {62'd0, oBusy, oDone}, 64'd0);
        rst = 1'b0;

        // MTHI then MTLO on consecutive cycles.
        iStart = 1'b1; iOp = 3'b100; iA = 32'h12345678;
        @(negedge clk);
        check("mthi", {32'd0, oHi}, {32'd0, 32'h12345678});
        check("mthi_busy", {63'd0, oBusy}, 64'd0);
        iOp = 3'b101; iA = 32'h9ABCDEF0;
        @(negedge clk);
        iStart = 1'b0;
        check("mtlo", {oHi, oLo}, 64'h12345678_9ABCDEF0);
        check("mtlo_busy", {63'd0, oBusy}, 64'd0);

        // NOP codes leave HI/LO untouched.
        iStart = 1'b1; iOp = 3'b110; iA = 32'hDEADBEEF;
        @(negedge clk);
        iOp = 3'b111;
        @(negedge clk);
        iStart = 1'b0;
        check("nop", {oHi, oLo}, 64'h12345678_9ABCDEF0);
        check("nop_busy", {63'd0, oBusy}, 64'd0);

        run_op("mult", 3'b000, 32'd7, 32'hFFFFFFFD);
        check("mult_const", {oHi, oLo}, 64'hFFFFFFFF_FFFFFFEB);
        run_op("multu", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("multu_const", {oHi, oLo}, 64'hFFFFFFFE_00000001);
        run_op("mult_min", 3'b000, 32'h80000000, 32'h80000000);
        run_op("div", 3'b010, 32'hFFFFFFF9, 32'd2);
        check("div_const", {oHi, oLo}, 64'hFFFFFFFF_FFFFFFFD);
        run_op("div_negb", 3'b010, 32'd7, 32'hFFFFFFFE);
        run_op("divu", 3'b011, 32'd100, 32'd7);
        check("divu_const", {oHi, oLo}, {32'd2, 32'd14});
        run_op("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF);
        check("div_ovf_const", {oHi, oLo}, 64'h00000000_80000000);
        run_op("divu_zero", 3'b011, 32'd5, 32'd0);
        check("divu_zero_const", {oHi, oLo}, {32'd5, 32'hFFFFFFFF});
        run_op("div_zero", 3'b010, 32'hFFFFFFFB, 32'd0);
        for (int i = 0; i < 4; i++) begin
            run_op("rand", 3'(i), $urandom, $urandom_range(1, 32'h0000FFFF));
        end

        // MTLO held during a running DIV must stall until the DIV finishes.
        sb_q.push_back(model(3'b010, 32'd1000, 32'hFFFFFFF3));
        old_lo = oLo;
        @(negedge clk);
        iStart = 1'b1; iOp = 3'b010; iA = 32'd1000; iB = 32'hFFFFFFF3;
        @(negedge clk);
        iOp = 3'b101; iA = 32'hCAFEF00D;
        stall_bad = 1'b0; lo_bad = 1'b0; cyc = 0;
        while (oBusy && cyc < 60) begin
            if (!oStall) stall_bad = 1'b1;
            if (oLo !== old_lo) lo_bad = 1'b1;
            @(negedge clk);
            cyc++;
        end
        check("stall_cycles", 64'(cyc), 64'd33);
        check("stall_high", {63'd0, stall_bad}, 64'd0);
        check("stall_lo_held", {63'd0, lo_bad}, 64'd0);
        check("stall_done", {63'd0, oDone}, 64'd1);
        check("stall_div", {oHi, oLo}, sb_q.pop_front());
        check("stall_release", {63'd0, oStall}, 64'd0);
        exp = {oHi, 32'hCAFEF00D};
        @(negedge clk);
        iStart = 1'b0;
        check("mtlo_after_div", {oHi, oLo}, exp);
        check("mtlo_after_div_busy", {63'd0, oBusy}, 64'd0);

        // Reset while the MULT counter sits at 10.
        @(negedge clk);
        iStart = 1'b1; iOp = 3'b000; iA = 32'd3; iB = 32'd5;
        @(negedge clk);
        iStart = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", {63'd0, oBusy}, 64'd0);
        check("midrst_hilo", {oHi, oLo}, 64'd0);
        check("midrst_done", {63'd0, oDone}, 64'd0);
        done_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (oDone || oBusy) done_seen = 1'b1;
        end
        check("midrst_quiet", {63'd0, done_seen}, 64'd0);

        // Reset and start on the same edge: reset only.
        iStart = 1'b1; iOp = 3'b001; iA = 32'd9; iB = 32'd9; rst = 1'b1;
        @(negedge clk);
        iStart = 1'b0; rst = 1'b0;
        check("rst_start_busy", {63'd0, oBusy}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
